// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: ID/IF-stage signals into the fetch sequencer and IF/ID register outputs.
interface fetch_sequencer_if;
  logic        stall;
  logic        and_z_b;
  logic [1:0]  Jmp;
  logic [31:0] branch_adder;
  logic [25:0] jmp_addr;
  logic [31:0] address_on_reg;
  logic [31:0] instruction;
  logic [31:0] out_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        redirect_pending;
  modport master (
    output stall, and_z_b, Jmp, branch_adder, jmp_addr, address_on_reg, instruction,
    input  out_pc, if_id_instr, if_id_pc4, if_id_valid, redirect_pending
  );
  modport slave (
    input  stall, and_z_b, Jmp, branch_adder, jmp_addr, address_on_reg, instruction,
    output out_pc, if_id_instr, if_id_pc4, if_id_valid, redirect_pending
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fills IF/ID, resolves ID redirects and defers those seen during stalls.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          PC_INCR   = 4
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        redirect_pending_q, redirect_pending_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] seq_pc, target, apply_pc;
  logic        is_j, is_jr, redirect, take, seq;
  assign seq_pc   = pc_q + 32'(PC_INCR);
  assign is_j     = bus.Jmp == 2'b01;
  assign is_jr    = bus.Jmp == 2'b10;
  assign redirect = bus.and_z_b | is_j | is_jr;
  assign target   = is_jr ? bus.address_on_reg :
                    is_j ? {pc4_q[31:28], bus.jmp_addr, 2'b00} :
                    bus.and_z_b ? bus.branch_adder : seq_pc;
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    instr_d            = instr_q;
    pc4_d              = pc4_q;
    valid_d            = valid_q;
    redirect_pending_d = redirect_pending_q;
    pending_pc_d       = pending_pc_q;
    take               = 1'b0;
    seq                = 1'b0;
    apply_pc           = target;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.stall) begin
          state_d = HOLD;
          if (redirect) begin
            pending_pc_d       = target;
            redirect_pending_d = 1'b1;
          end
        end else begin
          take = redirect;
          seq  = !redirect;
        end
      end
      HOLD: begin
        if (bus.stall) begin
          if (redirect) begin
            pending_pc_d       = target;
            redirect_pending_d = 1'b1;
          end
        end else begin
          // a live redirect on the release cycle is newer than the deferred one
          state_d            = RUN;
          take               = redirect | redirect_pending_q;
          seq                = !(redirect | redirect_pending_q);
          apply_pc           = redirect ? target : pending_pc_q;
          redirect_pending_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
    if (take) begin
      pc_d    = apply_pc;
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (seq) begin
      pc_d    = seq_pc;
      instr_d = bus.instruction;
      pc4_d   = seq_pc;
      valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= BOOT;
      pc_q               <= RESET_PC;
      instr_q            <= NOP_INSTR;
      pc4_q              <= 32'h0;
      valid_q            <= 1'b0;
      redirect_pending_q <= 1'b0;
      pending_pc_q       <= 32'h0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      instr_q            <= instr_d;
      pc4_q              <= pc4_d;
      valid_q            <= valid_d;
      redirect_pending_q <= redirect_pending_d;
      pending_pc_q       <= pending_pc_d;
    end
  end
  assign bus.out_pc           = pc_q;
  assign bus.if_id_instr      = instr_q;
  assign bus.if_id_pc4        = pc4_q;
  assign bus.if_id_valid      = valid_q;
  assign bus.redirect_pending = redirect_pending_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, hand-written reset corners, then random stimulus vs a reference model.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fetch_sequencer_if bus();
  fetch_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [31:0] ifn(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction
  assign bus.instruction = ifn(bus.out_pc);
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic        st, azb;
    logic [1:0]  jmp;
    logic [31:0] ba;
    logic [25:0] ja;
    logic [31:0] aor, pc, pc4;
    logic        v, pend;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] m_pc, m_pc4, m_ins, m_ppc;
  logic        m_v, m_pend, m_boot;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_all(string tag, logic [31:0] pc, logic [31:0] pc4, logic [31:0] ins, logic v, logic pend);
    chk({tag, " out_pc"}, bus.out_pc, pc);
    chk({tag, " if_id_pc4"}, bus.if_id_pc4, pc4);
    chk({tag, " if_id_instr"}, bus.if_id_instr, ins);
    chk({tag, " if_id_valid"}, 32'(bus.if_id_valid), 32'(v));
    chk({tag, " redirect_pending"}, 32'(bus.redirect_pending), 32'(pend));
  endtask
  task automatic drive(logic st, logic azb, logic [1:0] jmp, logic [31:0] ba, logic [25:0] ja, logic [31:0] aor);
    bus.stall = st;
    bus.and_z_b = azb;
    bus.Jmp = jmp;
    bus.branch_adder = ba;
    bus.jmp_addr = ja;
    bus.address_on_reg = aor;
  endtask
  task automatic add(logic st, logic azb, logic [1:0] jmp, logic [31:0] ba, logic [25:0] ja, logic [31:0] aor,
                     logic [31:0] pc, logic [31:0] pc4, logic v, logic pend);
    tbl.push_back('{st, azb, jmp, ba, ja, aor, pc, pc4, v, pend});
  endtask
  task automatic model_reset();
    m_pc = 0; m_pc4 = 0; m_ins = 0; m_ppc = 0; m_v = 0; m_pend = 0; m_boot = 1;
  endtask
  task automatic model_edge();
    logic        rd;
    logic [31:0] tgt;
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    rd  = bus.and_z_b || bus.Jmp == 2'b01 || bus.Jmp == 2'b10;
    tgt = bus.Jmp == 2'b10 ? bus.address_on_reg :
          bus.Jmp == 2'b01 ? {m_pc4[31:28], bus.jmp_addr, 2'b00} :
          bus.and_z_b ? bus.branch_adder : m_pc + 4;
    if (bus.stall) begin
      if (rd) begin
        m_pend = 1;
        m_ppc  = tgt;
      end
    end else if (rd || m_pend) begin
      m_pc   = rd ? tgt : m_ppc;
      m_ins  = 0;
      m_pc4  = 0;
      m_v    = 0;
      m_pend = 0;
    end else begin
      m_ins = ifn(m_pc);
      m_pc  = m_pc + 4;
      m_pc4 = m_pc;
      m_v   = 1;
    end
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk_all("in_reset", 0, 0, 0, 0, 0);
    rst = 1'b1;
    add(0,0,0,0,0,0,              32'h0,         0,             0,0);
    add(0,0,0,0,0,0,              32'h4,         32'h4,         1,0);
    add(0,0,0,0,0,0,              32'h8,         32'h8,         1,0);
    add(0,0,0,0,0,0,              32'hC,         32'hC,         1,0);
    add(0,0,0,0,0,0,              32'h10,        32'h10,        1,0);
    add(0,1,0,32'h40,0,0,         32'h40,        0,             0,0);
    add(0,0,0,0,0,0,              32'h44,        32'h44,        1,0);
    add(0,0,0,0,0,0,              32'h48,        32'h48,        1,0);
    add(0,1,0,32'h1000_0004,0,0,  32'h1000_0004, 0,             0,0);
    add(0,0,0,0,0,0,              32'h1000_0008, 32'h1000_0008, 1,0);
    add(0,0,1,0,26'h20,0,         32'h1000_0080, 0,             0,0);
    add(0,1,2,32'h999,0,32'h200,  32'h200,       0,             0,0);
    add(0,0,0,0,0,0,              32'h204,       32'h204,       1,0);
    add(1,1,0,32'h80,0,0,         32'h204,       32'h204,       1,1);
    add(1,0,0,0,0,0,              32'h204,       32'h204,       1,1);
    add(1,0,0,0,0,0,              32'h204,       32'h204,       1,1);
    add(0,0,0,0,0,0,              32'h80,        0,             0,0);
    add(0,0,0,0,0,0,              32'h84,        32'h84,        1,0);
    add(1,1,0,32'h300,0,0,        32'h84,        32'h84,        1,1);
    add(1,0,1,0,26'h40,0,         32'h84,        32'h84,        1,1);
    add(0,1,0,32'h500,0,0,        32'h500,       0,             0,0);
    add(0,0,0,0,0,0,              32'h504,       32'h504,       1,0);
    add(1,1,0,32'h600,0,0,        32'h504,       32'h504,       1,1);
    add(1,0,1,0,26'h40,0,         32'h504,       32'h504,       1,1);
    add(0,0,0,0,0,0,              32'h100,       0,             0,0);
    add(0,0,0,0,0,0,              32'h104,       32'h104,       1,0);
    add(1,0,0,0,0,0,              32'h104,       32'h104,       1,0);
    add(0,0,0,0,0,0,              32'h108,       32'h108,       1,0);
    add(0,0,3,0,26'h3,0,          32'h10C,       32'h10C,       1,0);
    add(0,1,0,32'hFFFF_FFFC,0,0,  32'hFFFF_FFFC, 0,             0,0);
    add(0,0,0,0,0,0,              32'h0,         32'h0,         1,0);
    add(0,0,0,0,0,0,              32'h4,         32'h4,         1,0);
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].azb, tbl[i].jmp, tbl[i].ba, tbl[i].ja, tbl[i].aor);
      @(posedge clk);
      #1 chk_all($sformatf("row%0d", i), tbl[i].pc, tbl[i].pc4,
                 tbl[i].v ? ifn(tbl[i].pc4 - 32'd4) : 32'h0, tbl[i].v, tbl[i].pend);
    end
    // async reset while holding a deferred redirect, then the BOOT edge again
    drive(1, 1, 0, 32'h80, 0, 0);
    @(posedge clk);
    #1 chk_all("hold_pend", 32'h4, 32'h4, ifn(32'h0), 1, 1);
    drive(1, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_all("boot_edge", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_all("post_boot", 32'h4, 32'h4, ifn(32'h0), 1, 0);
    rst = 1'b0;
    model_reset();
    #1 chk_all("rand_rst", m_pc, m_pc4, m_ins, m_v, m_pend);
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) < 2 ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom_range(0, 15) == 0 ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC),
            26'($urandom), $urandom & 32'hFFFF_FFFC);
      model_edge();
      @(posedge clk);
      #1 chk_all($sformatf("rand%0d", i), m_pc, m_pc4, m_ins, m_v, m_pend);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        model_reset();
        #1 chk_all($sformatf("rand%0d_rst", i), m_pc, m_pc4, m_ins, m_v, m_pend);
        rst = 1'b1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
